bp_update_scheduler: RTL
========================

Name: bp_update_scheduler

Overview:
- Single-write-port scheduler in front of the branch predictor tables (tag table, BHT, BTB).
- Serialises two update sources into one write per cycle:
  - ID-stage allocations: tag plus target, known at decode.
  - EX-stage training: taken/not-taken outcome at resolution.
- Runs the post-reset table-clear sweep and holds fetch off (busy) until the sweep completes.
- Sits between the ID/EX stage logic and the predictor.

Parameters:
- WORD_SIZE, 16, PC/target width.
- BTB_IDX_SIZE, 8, predictor index width; table has 2**BTB_IDX_SIZE entries.
- QUEUE_DEPTH, 4, pending-allocation queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset, sampled on posedge clk.
- flush  in  1  pipeline squash; discards queued allocations.
- alloc_valid  in  1  ID requests allocation.
- alloc_ready  out  1  queue can accept an allocation this cycle.
- alloc_pc  in  WORD_SIZE  PC of decoded branch/jump.
- alloc_target  in  WORD_SIZE  decoded target.
- train_valid  in  1  EX resolved a branch; always accepted, no ready.
- train_pc  in  WORD_SIZE  PC of resolved branch.
- train_taken  in  1  actual direction.
- busy  out  1  clear sweep in progress; fetch must stall.
- wr_alloc  out  1  write tag and target at wr_idx.
- wr_train  out  1  apply train to the BHT counter at wr_idx.
- wr_idx  out  BTB_IDX_SIZE  entry index.
- wr_tag  out  WORD_SIZE-BTB_IDX_SIZE  tag field.
- wr_target  out  WORD_SIZE  target.
- wr_taken  out  1  direction for training.
- wr_clear  out  1  clear entry wr_idx: tag 0, target 0, BHT 2'b10.

Behaviour:
- Reset (reset_n low at posedge):
  - state=CLEAR, clear counter=0, queue emptied.
  - All wr_* strobes 0, wr_idx/wr_tag/wr_target/wr_taken 0.
  - busy=1, alloc_ready=0.
- CLEAR state:
  - Each cycle, wr_clear=1 with wr_idx=counter; counter increments.
  - On the cycle counter=2**BTB_IDX_SIZE-1, issue the final clear, then state->RUN the next cycle; busy drops in that same next cycle.
  - Sweep takes exactly 2**BTB_IDX_SIZE cycles after reset release.
  - alloc/train inputs ignored in CLEAR.
  - reset_n low mid-sweep restarts at counter 0.
- RUN state: per-cycle priority, with outputs registered (1-cycle latency from input to wr_*).
  1. train_valid, with no queued entry whose idx matches train_pc[BTB_IDX_SIZE-1:0]:
     - Issue wr_train with its idx/tag/taken.
     - The queue head waits.
  2. train_valid with a matching queued entry (youngest match wins):
     - Merge: set that entry's train flag and store taken; no write this cycle.
     - If the head is not matched and no other train is pending, the head may drain.
  3. No train issued, queue non-empty: pop the head.
     - wr_alloc=1, plus wr_train=1 and wr_taken=flag if merged.
     - Same wr_idx for both strobes; tag/target from the entry.
  4. Otherwise all strobes 0.
- Queue push:
  - alloc_valid && alloc_ready pushes {idx, tag, target, train=0}.
  - alloc_ready = RUN && !full, where a same-cycle pop counts as freeing a slot.
  - Push and pop in the same cycle are allowed.
  - Full: alloc_ready=0; ID must hold.
  - Empty with no train: no writes.
- flush:
  - Empties the queue, dropping merged flags.
  - A train_valid in the same cycle still issues; it is never merged into flushed entries.
  - An alloc in the same cycle is discarded.
  - flush during CLEAR has no effect.
- Index/tag split: idx = pc[BTB_IDX_SIZE-1:0], tag = pc[WORD_SIZE-1:BTB_IDX_SIZE].
- Pointers wrap modulo QUEUE_DEPTH; an occupancy counter of width clog2(QUEUE_DEPTH)+1 distinguishes full from empty.

Optional Feature:
- Macro BP_SCHED_STATS_EN.
- Defined:
  - Extra outputs stat_trains, stat_merges, stat_full_cycles, each 16 bits.
  - Saturating at 16'hFFFF, cleared by reset.
  - Increment respectively on a train issued, a merge, and a RUN cycle with full and alloc_valid.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package bp_pkg holds:
  - WORD_SIZE.
  - BHT reset value 2'b10.
  - State encoding CLEAR/RUN.
  - Queue entry struct {idx, tag, target, train, taken}.
- Sub-module bp_update_fifo: parameterised circular queue, push/pop/flush/full/empty, associative idx-match lookup that returns the youngest matching slot, and per-slot merge write.

Test Plan:
- Release reset with BTB_IDX_SIZE=4 -> wr_clear for idx 0..15 over 16 cycles; busy=1 then 0 on cycle 17; alloc_ready=1.
- Alloc pc=16'h0123, target=16'h0200, no train -> next cycle wr_alloc=1, wr_idx=8'h23, wr_tag=8'h01, wr_target=16'h0200.
- Alloc pc=0x0123 and train pc=0x0456 taken in the same cycle -> cycle+1 wr_train idx 0x56; cycle+2 wr_alloc idx 0x23.
- Five allocs back-to-back with a continuous train stream on other indices (QUEUE_DEPTH=4) -> alloc_ready=0 after 4 pushes; no write lost when the trains stop.
- Alloc 0x0123 queued behind trains, then train 0x0123 not-taken -> single pop cycle with wr_alloc=1, wr_train=1, wr_taken=0.
- Queue holds 3 entries, flush with train_valid -> train issues; no wr_alloc afterwards; reset_n low mid-sweep -> sweep restarts at idx 0.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared types, constants and helpers for the branch-predictor update scheduler.
package bp_pkg;

   localparam int WORD_SIZE = 16;
   localparam logic [1:0] BHT_RESET = 2'b10;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } bp_state_e;

   // idx/tag are held zero-extended to WORD_SIZE so the entry layout does not depend on BTB_IDX_SIZE.
   typedef struct packed {
      logic [WORD_SIZE-1:0] idx;
      logic [WORD_SIZE-1:0] tag;
      logic [WORD_SIZE-1:0] target;
      logic                 train;
      logic                 taken;
   } bp_entry_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: circular queue of pending allocations with youngest-match lookup and
// per-slot merge of a training outcome.
module bp_update_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 flush,
   input  bp_entry_t            push_entry,
   input  logic [WORD_SIZE-1:0] match_idx,
   input  logic                 merge,
   input  logic                 merge_taken,
   output bp_entry_t            head_entry,
   output logic                 empty,
   output logic                 full,
   output logic                 match_hit,
   output logic                 match_is_head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   bp_entry_t        slots_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, match_slot;
   logic [CNT_W-1:0] count_q, count_d;

   assign empty         = (count_q == '0);
   assign full          = (count_q == CNT_W'(DEPTH));
   assign head_entry    = slots_q[head_q];
   assign match_is_head = match_hit && (match_slot == head_q);

   // Walk from oldest to youngest so the last hit is the youngest match.
   always_comb begin
      match_hit  = 1'b0;
      match_slot = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count_q) && (slots_q[head_q + PTR_W'(i)].idx == match_idx)) begin
            match_hit  = 1'b1;
            match_slot = head_q + PTR_W'(i);
         end
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + PTR_W'(1);
         if (pop)  head_d = head_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: slot storage is deliberately not reset; the occupancy count alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push) slots_q[tail_q] <= push_entry;
      if (merge) begin
         slots_q[match_slot].train <= 1'b1;
         slots_q[match_slot].taken <= merge_taken;
      end
   end

endmodule

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: serialises ID allocations and EX training into one predictor write per cycle.
// Define BP_SCHED_STATS_EN to add saturating train/merge/full-stall counters.
module bp_update_scheduler
   import bp_pkg::*;
#(
   parameter int BTB_IDX_SIZE = 8,
   parameter int QUEUE_DEPTH  = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              flush,
   input  logic                              alloc_valid,
   output logic                              alloc_ready,
   input  logic [WORD_SIZE-1:0]              alloc_pc,
   input  logic [WORD_SIZE-1:0]              alloc_target,
   input  logic                              train_valid,
   input  logic [WORD_SIZE-1:0]              train_pc,
   input  logic                              train_taken,
   output logic                              busy,
   output logic                              wr_alloc,
   output logic                              wr_train,
   output logic [BTB_IDX_SIZE-1:0]           wr_idx,
   output logic [WORD_SIZE-BTB_IDX_SIZE-1:0] wr_tag,
   output logic [WORD_SIZE-1:0]              wr_target,
   output logic                              wr_taken,
`ifdef BP_SCHED_STATS_EN
   output logic [15:0]                       stat_trains,
   output logic [15:0]                       stat_merges,
   output logic [15:0]                       stat_full_cycles,
`endif
   output logic                              wr_clear
);

   localparam int IDX_W = BTB_IDX_SIZE;
   localparam int TAG_W = WORD_SIZE - BTB_IDX_SIZE;
   localparam logic [IDX_W:0] SWEEP_END = {1'b1, {IDX_W{1'b0}}};

   bp_state_e        state_q, state_d;
   logic [IDX_W:0]   clr_cnt_q, clr_cnt_d;
   logic             busy_q, busy_d;
   logic             wr_alloc_q, wr_alloc_d, wr_train_q, wr_train_d;
   logic             wr_clear_q, wr_clear_d, wr_taken_q, wr_taken_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [TAG_W-1:0] wr_tag_q, wr_tag_d;
   logic [WORD_SIZE-1:0] wr_target_q, wr_target_d;

   logic run, issue_train, merge, pop, bypass, push;
   logic fifo_empty, fifo_full, match_hit, match_is_head;
   bp_entry_t head_entry, alloc_entry;
   logic unused_hi;

   assign run         = (state_q == ST_RUN);
   assign issue_train = run && train_valid && (flush || !match_hit);
   assign merge       = run && train_valid && !flush && match_hit;
   assign pop         = run && !flush && !fifo_empty && !issue_train && !(merge && match_is_head);
   // An alloc reaching an empty queue with no train competing is written straight through.
   assign bypass      = run && !flush && fifo_empty && alloc_valid && !train_valid;
   assign alloc_ready = run && (!fifo_full || pop);
   assign push        = alloc_valid && alloc_ready && !flush && !bypass;
   assign unused_hi   = ^{head_entry.idx[WORD_SIZE-1:IDX_W], head_entry.tag[WORD_SIZE-1:TAG_W]};

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      alloc_entry        = '0;
      alloc_entry.idx    = WORD_SIZE'(alloc_pc[IDX_W-1:0]);
      alloc_entry.tag    = WORD_SIZE'(alloc_pc[WORD_SIZE-1:IDX_W]);
      alloc_entry.target = alloc_target;
   end

   bp_update_fifo #(
      .DEPTH(QUEUE_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset_n      (reset_n),
      .push         (push),
      .pop          (pop),
      .flush        (flush && run),
      .push_entry   (alloc_entry),
      .match_idx    (WORD_SIZE'(train_pc[IDX_W-1:0])),
      .merge        (merge),
      .merge_taken  (train_taken),
      .head_entry   (head_entry),
      .empty        (fifo_empty),
      .full         (fifo_full),
      .match_hit    (match_hit),
      .match_is_head(match_is_head)
   );

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      busy_d      = busy_q;
      wr_alloc_d  = 1'b0;
      wr_train_d  = 1'b0;
      wr_clear_d  = 1'b0;
      wr_taken_d  = 1'b0;
      wr_idx_d    = '0;
      wr_tag_d    = '0;
      wr_target_d = '0;
      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == SWEEP_END) begin
               state_d = ST_RUN;
               busy_d  = 1'b0;
            end else begin
               wr_clear_d = 1'b1;
               wr_idx_d   = clr_cnt_q[IDX_W-1:0];
               clr_cnt_d  = clr_cnt_q + {{IDX_W{1'b0}}, 1'b1};
            end
         end
         ST_RUN: begin
            if (issue_train) begin
               wr_train_d = 1'b1;
               wr_idx_d   = train_pc[IDX_W-1:0];
               wr_tag_d   = train_pc[WORD_SIZE-1:IDX_W];
               wr_taken_d = train_taken;
            end else if (pop) begin
               wr_alloc_d  = 1'b1;
               wr_train_d  = head_entry.train;
               wr_taken_d  = head_entry.taken;
               wr_idx_d    = head_entry.idx[IDX_W-1:0];
               wr_tag_d    = head_entry.tag[TAG_W-1:0];
               wr_target_d = head_entry.target;
            end else if (bypass) begin
               wr_alloc_d  = 1'b1;
               wr_idx_d    = alloc_pc[IDX_W-1:0];
               wr_tag_d    = alloc_pc[WORD_SIZE-1:IDX_W];
               wr_target_d = alloc_target;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_CLEAR;
         clr_cnt_q   <= '0;
         busy_q      <= 1'b1;
         wr_alloc_q  <= 1'b0;
         wr_train_q  <= 1'b0;
         wr_clear_q  <= 1'b0;
         wr_taken_q  <= 1'b0;
         wr_idx_q    <= '0;
         wr_tag_q    <= '0;
         wr_target_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         busy_q      <= busy_d;
         wr_alloc_q  <= wr_alloc_d;
         wr_train_q  <= wr_train_d;
         wr_clear_q  <= wr_clear_d;
         wr_taken_q  <= wr_taken_d;
         wr_idx_q    <= wr_idx_d;
         wr_tag_q    <= wr_tag_d;
         wr_target_q <= wr_target_d;
      end
   end

   assign busy      = busy_q;
   assign wr_alloc  = wr_alloc_q;
   assign wr_train  = wr_train_q;
   assign wr_clear  = wr_clear_q;
   assign wr_taken  = wr_taken_q;
   assign wr_idx    = wr_idx_q;
   assign wr_tag    = wr_tag_q;
   assign wr_target = wr_target_q;

`ifdef BP_SCHED_STATS_EN
   logic [15:0] stat_trains_q, stat_trains_d;
   logic [15:0] stat_merges_q, stat_merges_d;
   logic [15:0] stat_full_q, stat_full_d;

   always_comb begin
      stat_trains_d = issue_train ? sat_inc16(stat_trains_q) : stat_trains_q;
      stat_merges_d = merge ? sat_inc16(stat_merges_q) : stat_merges_q;
      stat_full_d   = (run && fifo_full && alloc_valid) ? sat_inc16(stat_full_q) : stat_full_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stat_trains_q <= '0;
         stat_merges_q <= '0;
         stat_full_q   <= '0;
      end else begin
         stat_trains_q <= stat_trains_d;
         stat_merges_q <= stat_merges_d;
         stat_full_q   <= stat_full_d;
      end
   end

   assign stat_trains      = stat_trains_q;
   assign stat_merges      = stat_merges_q;
   assign stat_full_cycles = stat_full_q;
`endif

endmodule
